// File: rtl/mux_probe_checker.sv
// Checks a 2:1 mux probe bus, counts samples and errors, and queues offending words in a small FIFO.
// Optional build macro MUX_CHK_STOP_ON_ERR_EN: halt on the first mismatch until clear.
module mux_probe_checker #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             clear,
    input  logic             probe_valid,
    output logic             probe_ready,
    input  logic [8:0]       probe,
    output logic             rec_valid,
    input  logic             rec_ready,
    output logic [8:0]       rec_data,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             running,
    output logic             halted
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t           state_q;
    logic [8:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, rd_q;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0] sample_q, sample_d, err_q, err_d;
    logic             full, accept, mismatch, push, pop;

    assign full        = (cnt_q == (PTR_W+1)'(DEPTH));
    assign probe_ready = (state_q == RUN) && !full;
    assign accept      = probe_valid && probe_ready;
    assign mismatch    = (probe[8] != (probe[2] ? probe[1] : probe[0])) || (probe[3] != probe[2]);
    assign push        = accept && mismatch;
    assign rec_valid   = (cnt_q != '0);
    assign pop         = rec_valid && rec_ready;
    assign rec_data    = mem_q[rd_q];
    assign sample_cnt  = sample_q;
    assign err_cnt     = err_q;
    assign running     = (state_q == RUN);
    assign halted      = (state_q == HALT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else if (clear) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: if (start) state_q <= RUN;
                RUN: begin
`ifdef MUX_CHK_STOP_ON_ERR_EN
                    if (push) state_q <= HALT;
`endif
                end
                HALT:    state_q <= HALT;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop)      cnt_d = cnt_q + (PTR_W+1)'(1);
        else if (pop && !push) cnt_d = cnt_q - (PTR_W+1)'(1);

        sample_d = sample_q;
        err_d    = err_q;
        if (accept && (sample_q != '1)) sample_d = sample_q + CNT_W'(1);
        if (push && (err_q != '1))      err_d    = err_q + CNT_W'(1);
    end

    // clear wins over push/pop in the same cycle, so a pop requested then is dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q     <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
            sample_q <= '0;
            err_q    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (clear) begin
            wr_q     <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
            sample_q <= '0;
            err_q    <= '0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= probe;
                wr_q        <= wr_q + PTR_W'(1);
            end
            if (pop) rd_q <= rd_q + PTR_W'(1);
            cnt_q    <= cnt_d;
            sample_q <= sample_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_mux_probe_checker.sv
// Directed bench for mux_probe_checker (DEPTH=4, CNT_W=4 so saturation is reachable).
module tb_mux_probe_checker;

    logic       clk = 1'b0;
    logic       rst, start, clear, probe_valid, rec_ready;
    logic [8:0] probe;
    logic       probe_ready, rec_valid, running, halted;
    logic [8:0] rec_data;
    logic [3:0] sample_cnt, err_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int n_rdy;

    mux_probe_checker #(.DEPTH(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .clear(clear),
        .probe_valid(probe_valid), .probe_ready(probe_ready), .probe(probe),
        .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_data(rec_data),
        .sample_cnt(sample_cnt), .err_cnt(err_cnt),
        .running(running), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        clear = 1'b1; tick(); clear = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ready"},  32'(probe_ready), 32'h0);
        check_eq({tag, "_rvalid"}, 32'(rec_valid),   32'h0);
        check_eq({tag, "_rdata"},  32'(rec_data),    32'h0);
        check_eq({tag, "_samp"},   32'(sample_cnt),  32'h0);
        check_eq({tag, "_err"},    32'(err_cnt),     32'h0);
        check_eq({tag, "_run"},    32'(running),     32'h0);
        check_eq({tag, "_halt"},   32'(halted),      32'h0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; clear = 1'b0; probe_valid = 1'b0;
        rec_ready = 1'b0; probe = '0;
        #2;
        check_all_zero("rst");
        tick(); tick();
        rst = 1'b0;
        tick();
        check_eq("idle_run", 32'(running), 32'h0);

        // good words: S=1 selects I1=1, out=1
        pulse_start();
        check_eq("start_run", 32'(running), 32'h1);
        check_eq("start_ready", 32'(probe_ready), 32'h1);
        probe = 9'h15E; probe_valid = 1'b1;
        repeat (3) tick();
        probe_valid = 1'b0;
        check_eq("good_samp", 32'(sample_cnt), 32'h3);
        check_eq("good_err", 32'(err_cnt), 32'h0);
        check_eq("good_rvalid", 32'(rec_valid), 32'h0);

        pulse_clear();
        check_eq("clr_samp", 32'(sample_cnt), 32'h0);
        check_eq("clr_run", 32'(running), 32'h0);

        // one bad word: S=0, I0=1, out=0
        pulse_start();
        probe = 9'h011; probe_valid = 1'b1;
        tick();
        probe_valid = 1'b0;
        check_eq("bad_err", 32'(err_cnt), 32'h1);
        check_eq("bad_samp", 32'(sample_cnt), 32'h1);
        check_eq("bad_rvalid", 32'(rec_valid), 32'h1);
        check_eq("bad_rdata", 32'(rec_data), 32'h011);
`ifdef MUX_CHK_STOP_ON_ERR_EN
        check_eq("bad_halt", 32'(halted), 32'h1);
        check_eq("bad_ready", 32'(probe_ready), 32'h0);
`else
        check_eq("bad_halt", 32'(halted), 32'h0);
        check_eq("bad_ready", 32'(probe_ready), 32'h1);

        // fill the FIFO with consumer stalled
        pulse_clear();
        pulse_start();
        probe = 9'h011; probe_valid = 1'b1; n_rdy = 0;
        for (int i = 0; i < 6; i++) begin
            if (probe_ready) n_rdy++;
            tick();
        end
        check_eq("full_accepts", 32'(n_rdy), 32'h4);
        check_eq("full_err", 32'(err_cnt), 32'h4);
        check_eq("full_ready", 32'(probe_ready), 32'h0);
        rec_ready = 1'b1; tick(); rec_ready = 1'b0;
        check_eq("full_samp_held", 32'(sample_cnt), 32'h4);
        check_eq("pop_ready", 32'(probe_ready), 32'h1);
        tick();
        probe_valid = 1'b0;
        check_eq("fifth_err", 32'(err_cnt), 32'h5);
        check_eq("fifth_samp", 32'(sample_cnt), 32'h5);
        check_eq("refull_ready", 32'(probe_ready), 32'h0);

        // concurrent push and pop with two queued records
        pulse_clear();
        check_eq("clr_rvalid", 32'(rec_valid), 32'h0);
        pulse_start();
        probe_valid = 1'b1;
        probe = 9'h011; tick();
        probe = 9'h004; tick();
        probe = 9'h001; rec_ready = 1'b1; tick();
        probe_valid = 1'b0;
        check_eq("cc_head_b", 32'(rec_data), 32'h004);
        check_eq("cc_err", 32'(err_cnt), 32'h3);
        tick();
        check_eq("cc_head_c", 32'(rec_data), 32'h001);
        check_eq("cc_rvalid_c", 32'(rec_valid), 32'h1);
        tick();
        rec_ready = 1'b0;
        check_eq("cc_empty", 32'(rec_valid), 32'h0);

        // saturation: 17 bad words with the consumer draining
        pulse_clear();
        pulse_start();
        rec_ready = 1'b1; probe = 9'h011; probe_valid = 1'b1;
        repeat (15) tick();
        check_eq("sat15_samp", 32'(sample_cnt), 32'hF);
        repeat (2) tick();
        probe_valid = 1'b0;
        check_eq("sat_samp", 32'(sample_cnt), 32'hF);
        check_eq("sat_err", 32'(err_cnt), 32'hF);
        tick();
        rec_ready = 1'b0;

        // reset mid-stream with records queued
        pulse_clear();
        pulse_start();
        probe = 9'h011; probe_valid = 1'b1;
        repeat (3) tick();
        probe_valid = 1'b0;
        check_eq("pre_rst_rvalid", 32'(rec_valid), 32'h1);
        check_eq("pre_rst_err", 32'(err_cnt), 32'h3);
        rst = 1'b1;
        #1;
        check_all_zero("mid_rst");
        tick();
        rst = 1'b0;
        probe_valid = 1'b1;
        tick();
        probe_valid = 1'b0;
        check_eq("post_rst_samp", 32'(sample_cnt), 32'h0);
        check_eq("post_rst_run", 32'(running), 32'h0);
        start = 1'b1; clear = 1'b1; tick(); start = 1'b0; clear = 1'b0;
        check_eq("clr_start_run", 32'(running), 32'h0);
        pulse_start();
        check_eq("resume_run", 32'(running), 32'h1);
        check_eq("resume_rvalid", 32'(rec_valid), 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
